spart_tx: RTL and testbench



---
 rtl/spart_tx_if.sv | 30 +++
 rtl/spart_tx.sv | 122 ++++++++++++
 tb/tb_spart_tx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_tx_if.sv
// Bus-side signals of the SPART transmitter: write strobe/data, baud enable,
// buffer status and the serial line itself.
interface spart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_en;
    logic                 wr_en;
    logic [DATA_BITS-1:0] data_in;
    logic                 txd;
    logic                 tbr;
    logic                 tx_busy;

    modport master (
        output baud_en,
        output wr_en,
        output data_in,
        input  txd,
        input  tbr,
        input  tx_busy
    );

    modport slave (
        input  baud_en,
        input  wr_en,
        input  data_in,
        output txd,
        output tbr,
        output tx_busy
    );
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: holding register feeding a shift register, framed as
// start(0) + DATA_BITS LSB-first + stop(1), with bits timed in baud_en pulses.
module spart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input logic       clk,
    input logic       rst,
    spart_tx_if.slave bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tbr_q, tbr_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;
    logic                 load;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        tbr_d     = tbr_q;

        bit_end = (state_q != S_IDLE) && bus.baud_en && (cnt_q == CNT_LAST);
        // Holding byte moves on when the line is free or the stop bit is just ending
        load    = !tbr_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

        if ((state_q != S_IDLE) && bus.baud_en) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
            end
        endcase

        if (load) begin
            state_d = S_START;
            shift_d = hold_q;
            cnt_d   = '0;
            tbr_d   = 1'b1;
        end

        // tbr_q is low whenever load is possible, so these never collide
        if (bus.wr_en && tbr_q) begin
            hold_d = bus.data_in;
            tbr_d  = 1'b0;
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tbr_q     <= 1'b1;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tbr_q     <= tbr_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.txd     = txd_q;
    assign bus.tbr     = tbr_q;
    assign bus.tx_busy = busy_q;
endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: a UART-style receiver pops expected bytes from a
// scoreboard queue; an edge logger measures bit and busy timing in clocks.
module tb_spart_tx;
    localparam int OVS     = 16;
    localparam int BDIV    = 4;
    localparam int BIT_CLK = OVS * BDIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spart_tx_if #(.DATA_BITS(8)) bif ();

    spart_tx #(.OVERSAMPLE(OVS), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] exp_q[$];
    int         edges[$];
    bit         log_en    = 1'b0;
    bit         rx_en     = 1'b0;
    bit         baud_hold = 1'b0;
    int         busy_rise = 0, busy_fall = 0, busy_rises = 0, busy_falls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // baud generator, driven on the falling edge
    initial begin : baud_gen
        int bcnt;
        bcnt = 0;
        bif.baud_en = 1'b0;
        forever begin
            @(negedge clk);
            if (baud_hold) begin
                bif.baud_en = 1'b0;
            end else begin
                bif.baud_en = (bcnt == BDIV - 1);
                bcnt = (bcnt == BDIV - 1) ? 0 : bcnt + 1;
            end
        end
    end

    initial begin : edge_logger
        logic last_txd, last_busy;
        last_txd = 1'b1;
        last_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (log_en) begin
                if (bif.txd !== last_txd) edges.push_back(cyc);
                if (!last_busy && bif.tx_busy) begin busy_rise = cyc; busy_rises++; end
                if (last_busy && !bif.tx_busy) begin busy_fall = cyc; busy_falls++; end
            end
            last_txd  = bif.txd;
            last_busy = bif.tx_busy;
        end
    end

    task automatic wait_pulses(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk); #1;
            if (bif.baud_en) k++;
        end
    endtask

    initial begin : receiver
        logic [7:0] b;
        logic       prev;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rx_en && prev && !bif.txd && !rst) begin
                wait_pulses(OVS / 2);
                chk("rx_start", bif.txd, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    wait_pulses(OVS);
                    b[i] = bif.txd;
                end
                wait_pulses(OVS);
                chk("rx_stop", bif.txd, 1'b1);
                chk("rx_busy", bif.tx_busy, 1'b1);
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected_byte", b, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_byte", b, e);
                    $display("frame rx=0x%02h exp=0x%02h", b, e);
                end
            end
            prev = bif.txd;
        end
    end

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        bif.wr_en   = 1'b1;
        bif.data_in = d;
        @(negedge clk);
        bif.wr_en   = 1'b0;
    endtask

    task automatic wait_tbr(input int lim);
        int n = 0;
        while (bif.tbr !== 1'b1 && n < lim) begin @(posedge clk); #1; n++; end
        chk("to_tbr", n < lim, 1'b1);
    endtask

    task automatic wait_txd_fall(input int lim, output int at);
        int n = 0;
        while (bif.txd !== 1'b0 && n < lim) begin @(posedge clk); #1; n++; end
        chk("to_txd_fall", n < lim, 1'b1);
        at = cyc;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!(bif.tx_busy === 1'b0 && bif.tbr === 1'b1 && exp_q.size() == 0) && n < lim) begin
            @(posedge clk); #1; n++;
        end
        chk("to_idle", n < lim, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic log_start();
        edges.delete();
        busy_rises = 0;
        busy_falls = 0;
        log_en = 1'b1;
    endtask

    // checks a 0x55 frame: 10 txd edges, 64-clk data/stop bits
    task automatic check_55(input string tag, input int start_min, input int start_max);
        chk({tag, "_edges"}, edges.size(), 10);
        if (edges.size() == 10) begin
            chk({tag, "_start_len"}, (edges[1] - edges[0] >= start_min) &&
                                     (edges[1] - edges[0] <= start_max), 1'b1);
            for (int i = 1; i < 9; i++)
                chk({tag, "_bit_len"}, edges[i+1] - edges[i], BIT_CLK);
            chk({tag, "_stop_len"}, busy_fall - edges[9], BIT_CLK);
            chk({tag, "_busy_rise"}, busy_rise, edges[0]);
        end
    endtask

    initial begin : main
        int n, viol, t_fall;
        bif.wr_en   = 1'b0;
        bif.data_in = 8'h00;

        // 1: reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", bif.txd, 1'b1);
        chk("rst_tbr", bif.tbr, 1'b1);
        chk("rst_busy", bif.tx_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (bif.txd !== 1'b1 || bif.tbr !== 1'b1 || bif.tx_busy !== 1'b0) viol++;
        end
        chk("t1_idle_viol", viol, 0);
        rx_en = 1'b1;

        // 2: single 0x55 frame, timing
        log_start();
        exp_q.push_back(8'h55);
        wr(8'h55);
        n = 0;
        while (bif.tbr == 1'b0 && n < 10) begin n++; @(posedge clk); #1; end
        chk("t2_tbr_low_1to2", (n >= 1) && (n <= 2), 1'b1);
        wait_idle(2000);
        log_en = 1'b0;
        check_55("t2", BIT_CLK - 4, BIT_CLK + 4);
        chk("t2_busy_span", (busy_fall - busy_rise >= 10*BIT_CLK - 4) &&
                            (busy_fall - busy_rise <= 10*BIT_CLK + 4), 1'b1);

        // 3: back-to-back 0xA3, 0x0F
        log_start();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        wr(8'hA3);
        wait_tbr(100);
        wr(8'h0F);
        chk("t3_tbr_full", bif.tbr, 1'b0);
        wait_idle(4000);
        log_en = 1'b0;
        chk("t3_busy_rises", busy_rises, 1);
        chk("t3_busy_falls", busy_falls, 1);
        chk("t3_busy_span", (busy_fall - busy_rise >= 20*BIT_CLK - 4) &&
                            (busy_fall - busy_rise <= 20*BIT_CLK + 4), 1'b1);

        // 4: write while holding full is ignored
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        wr(8'h11);
        wait_tbr(100);
        wr(8'h22);
        chk("t4_tbr_full", bif.tbr, 1'b0);
        wr(8'hFF);
        chk("t4_tbr_after_ignored", bif.tbr, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        chk("t4_tbr_still_full", bif.tbr, 1'b0);
        wait_idle(4000);

        // 5: reset during data bit 3 of 0x81, pending 0x99 discarded
        rx_en = 1'b0;
        wr(8'h81);
        wait_txd_fall(50, t_fall);
        wr(8'h99);
        while (cyc < t_fall + 4*BIT_CLK + BIT_CLK/2) begin @(posedge clk); #1; end
        chk("t5_bit3", bif.txd, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_txd", bif.txd, 1'b1);
        chk("t5_rst_tbr", bif.tbr, 1'b1);
        chk("t5_rst_busy", bif.tx_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bif.txd !== 1'b1 || bif.tx_busy !== 1'b0) viol++;
        end
        chk("t5_no_stale_frame", viol, 0);
        rx_en = 1'b1;
        exp_q.push_back(8'h42);
        wr(8'h42);
        wait_idle(2000);

        // 6: baud_en stalled during the start bit
        log_start();
        exp_q.push_back(8'h55);
        wr(8'h55);
        wait_txd_fall(50, t_fall);
        baud_hold = 1'b1;
        viol = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (bif.txd !== 1'b0 || bif.tx_busy !== 1'b1) viol++;
        end
        chk("t6_hold_viol", viol, 0);
        baud_hold = 1'b0;
        wait_idle(3000);
        log_en = 1'b0;
        check_55("t6", 200, 200 + 2*BIT_CLK);

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
